uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 143 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered UART transmitter with runtime parity and stop-bit selection.
// Config is captured with each popped word so a frame is immune to mid-frame changes.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    input  logic [1:0]                    i_Parity_Mode,
    input  logic                          i_Two_Stop,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop;
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n, bit_nx;
    logic                 stop_idx, stop_n;
    logic [DATA_BITS-1:0] data_q;
    logic [1:0]           par_q;
    logic                 two_q;
    logic                 serial_n, done_n, last, has_par, par_bit;

    assign o_Tx_Ready = o_Fifo_Count != FULL;
    assign push       = i_Tx_DV && o_Tx_Ready;
    assign last       = cnt == CMAX;
    assign has_par    = par_q[0] ^ par_q[1];
    assign par_bit    = ^data_q ^ par_q[1];
    assign bit_nx     = bit_idx + 1'b1;

    always_ff @(posedge i_Clock)
        if (push) mem[wr_ptr] <= i_Tx_Byte;

    always_ff @(posedge i_Clock or posedge i_Reset)
        if (i_Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_Fifo_Count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            o_Fifo_Count <= o_Fifo_Count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end

    always_comb begin
        state_n  = state;
        cnt_n    = last ? '0 : cnt + 1'b1;
        bit_n    = bit_idx;
        stop_n   = stop_idx;
        serial_n = o_Tx_Serial;
        done_n   = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                cnt_n    = '0;
                serial_n = 1'b1;
                if (o_Fifo_Count != 0) begin
                    pop      = 1'b1;
                    state_n  = START;
                    serial_n = 1'b0;
                end
            end
            START: if (last) begin
                state_n  = DATA;
                bit_n    = '0;
                serial_n = data_q[0];
            end
            DATA: if (last) begin
                if (bit_idx == BMAX) begin
                    state_n  = has_par ? PARITY : STOP;
                    serial_n = has_par ? par_bit : 1'b1;
                    stop_n   = 1'b0;
                end else begin
                    bit_n    = bit_nx;
                    serial_n = data_q[bit_nx];
                end
            end
            PARITY: if (last) begin
                state_n  = STOP;
                serial_n = 1'b1;
                stop_n   = 1'b0;
            end
            STOP: if (last) begin
                if (two_q && !stop_idx) stop_n = 1'b1;
                else begin
                    done_n   = 1'b1;
                    pop      = o_Fifo_Count != 0;
                    state_n  = pop ? START : IDLE;
                    serial_n = !pop;
                end
            end
            default: begin
                state_n  = IDLE;
                cnt_n    = '0;
                serial_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset)
        if (i_Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            data_q      <= '0;
            par_q       <= '0;
            two_q       <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            stop_idx    <= stop_n;
            o_Tx_Serial <= serial_n;
            o_Tx_Active <= state_n != IDLE;
            o_Tx_Done   <= done_n;
            if (pop) begin
                data_q <= mem[rd_ptr];
                par_q  <= i_Parity_Mode;
                two_q  <= i_Two_Stop;
            end
        end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed frame checks for uart_tx_cfg at 4 clocks per bit plus a 5-bit parity instance
module tb_uart_tx_cfg;
  logic       clk = 0;
  logic       rst = 0;
  logic       dv = 0, dv5 = 0;
  logic [7:0] byte_in = 0;
  logic [4:0] byte5 = 0;
  logic [1:0] pm = 0;
  logic       two = 0;
  logic       ready, active, serial, done;
  logic       ready5, active5, serial5, done5;
  logic [2:0] count, count5;
  int         tests = 0, fails = 0;
  always #5 clk = ~clk;
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(byte_in),
    .i_Parity_Mode(pm), .i_Two_Stop(two), .o_Tx_Ready(ready),
    .o_Tx_Active(active), .o_Tx_Serial(serial), .o_Tx_Done(done),
    .o_Fifo_Count(count));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv5), .i_Tx_Byte(byte5),
    .i_Parity_Mode(pm), .i_Two_Stop(two), .o_Tx_Ready(ready5),
    .o_Tx_Active(active5), .o_Tx_Serial(serial5), .o_Tx_Done(done5),
    .o_Fifo_Count(count5));
  function automatic logic [63:0] expand(input logic [15:0] bits, input int periods);
    logic [63:0] r = '0;
    for (int p = 0; p < periods; p++)
      for (int c = 0; c < 4; c++) r[4*p+c] = bits[p];
    return r;
  endfunction
  task automatic write_word(input int which, input logic [7:0] d, input logic [1:0] mode, input logic ts);
    @(negedge clk);
    pm = mode;
    two = ts;
    if (which != 0) begin dv5 = 1; byte5 = d[4:0]; end
    else begin dv = 1; byte_in = d; end
    @(negedge clk);
    dv = 0;
    dv5 = 0;
  endtask
  task automatic capture(input int which, input int n, input int tog_at, input logic [1:0] tog_mode,
                         output logic [63:0] line, output logic [63:0] dn, output logic [63:0] act);
    line = '0; dn = '0; act = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      line[i] = which != 0 ? serial5 : serial;
      dn[i]   = which != 0 ? done5 : done;
      act[i]  = which != 0 ? active5 : active;
      if (i == tog_at) pm = tog_mode;
    end
  endtask
  task automatic test_reset;
    #1 rst = 1;
    #1;
    tests++;
    if ({serial, active, done, ready, count} !== 7'b1_0_0_1_000) begin
      fails++;
      $display("FAIL reset_async: got s/a/d/r/cnt=%b, want 1001000", {serial, active, done, ready, count});
    end
    tests++;
    if ({serial5, active5, done5, ready5, count5} !== 7'b1_0_0_1_000) begin
      fails++;
      $display("FAIL reset_async5: got %b, want 1001000", {serial5, active5, done5, ready5, count5});
    end
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({serial, active, count} !== 5'b1_0_000) begin
      fails++;
      $display("FAIL idle_after_reset: got s/a/cnt=%b, want 10000", {serial, active, count});
    end
  endtask
  task automatic test_frame_a5;
    logic [63:0] line, dn, act, exp;
    write_word(0, 8'hA5, 2'b00, 1'b0);
    tests++;
    if (serial !== 1'b1) begin
      fails++;
      $display("FAIL latency_pre: serial=%b one cycle after write, want 1", serial);
    end
    capture(0, 41, -1, 2'b00, line, dn, act);
    exp = expand({6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    exp[40] = 1'b1;
    tests++;
    if (line[0] !== 1'b0) begin
      fails++;
      $display("FAIL latency_start: serial=%b two cycles after write, want 0", line[0]);
    end
    tests++;
    if (line !== exp) begin
      fails++;
      $display("FAIL a5_line: got %h, want %h", line, exp);
    end
    tests++;
    if (dn !== 64'b1 << 40) begin
      fails++;
      $display("FAIL a5_done: got %h, want %h", dn, 64'b1 << 40);
    end
    tests++;
    if (act !== (64'b1 << 40) - 1) begin
      fails++;
      $display("FAIL a5_active: got %h, want %h", act, (64'b1 << 40) - 1);
    end
  endtask
  task automatic test_parity;
    logic [63:0] line, dn, act, exp;
    write_word(0, 8'h07, 2'b01, 1'b0);
    capture(0, 45, -1, 2'b00, line, dn, act);
    exp = expand({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    exp[44] = 1'b1;
    tests++;
    if (line !== exp) begin
      fails++;
      $display("FAIL even_line: got %h, want %h", line, exp);
    end
    tests++;
    if (dn !== 64'b1 << 44) begin
      fails++;
      $display("FAIL even_done: got %h, want %h", dn, 64'b1 << 44);
    end
    write_word(0, 8'h07, 2'b10, 1'b0);
    capture(0, 45, 20, 2'b01, line, dn, act);
    exp = expand({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    exp[44] = 1'b1;
    tests++;
    if (line !== exp) begin
      fails++;
      $display("FAIL odd_toggle_line: got %h, want %h", line, exp);
    end
    tests++;
    if (dn !== 64'b1 << 44) begin
      fails++;
      $display("FAIL odd_done: got %h, want %h", dn, 64'b1 << 44);
    end
  endtask
  task automatic test_two_stop;
    logic [63:0] line, dn, act, exp;
    write_word(0, 8'h00, 2'b00, 1'b1);
    capture(0, 45, -1, 2'b00, line, dn, act);
    exp = expand({5'b0, 2'b11, 8'h00, 1'b0}, 11);
    exp[44] = 1'b1;
    tests++;
    if (line !== exp) begin
      fails++;
      $display("FAIL two_stop_line: got %h, want %h", line, exp);
    end
    tests++;
    if (dn !== 64'b1 << 44) begin
      fails++;
      $display("FAIL two_stop_done: got %h, want %h", dn, 64'b1 << 44);
    end
    tests++;
    if (act !== (64'b1 << 44) - 1) begin
      fails++;
      $display("FAIL two_stop_active: got %h, want %h", act, (64'b1 << 44) - 1);
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0]  w [6];
    logic        s_ser [210], s_act [210], s_done [210], s_rdy [210];
    logic [2:0]  s_cnt [210];
    logic [39:0] got;
    logic [63:0] exp;
    int          bad_d, bad_a, bad_i;
    w = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'h5A, 8'hEE};
    @(negedge clk);
    pm = 2'b00;
    two = 1'b0;
    dv = 1;
    byte_in = w[0];
    for (int i = 0; i < 210; i++) begin
      @(negedge clk);
      s_ser[i] = serial; s_act[i] = active; s_done[i] = done; s_rdy[i] = ready; s_cnt[i] = count;
      dv = i < 5;
      if (i < 5) byte_in = w[i+1];
    end
    tests++;
    if ({s_cnt[0], s_cnt[1], s_cnt[2], s_cnt[3], s_cnt[4]} !== {3'd1, 3'd1, 3'd2, 3'd3, 3'd4}) begin
      fails++;
      $display("FAIL b2b_count: got %0d,%0d,%0d,%0d,%0d, want 1,1,2,3,4",
               s_cnt[0], s_cnt[1], s_cnt[2], s_cnt[3], s_cnt[4]);
    end
    tests++;
    if ({s_rdy[3], s_rdy[4], s_rdy[5]} !== 3'b100) begin
      fails++;
      $display("FAIL b2b_ready: got %b after edges 3..5, want 100", {s_rdy[3], s_rdy[4], s_rdy[5]});
    end
    for (int k = 0; k < 5; k++) begin
      for (int m = 0; m < 40; m++) got[m] = s_ser[1 + 40*k + m];
      exp = expand({6'b0, 1'b1, w[k], 1'b0}, 10);
      tests++;
      if (got !== exp[39:0]) begin
        fails++;
        $display("FAIL b2b_frame%0d: got %h, want %h", k, got, exp[39:0]);
      end
    end
    bad_d = 0; bad_a = 0; bad_i = 0;
    for (int i = 0; i < 210; i++) begin
      if (s_done[i] !== (i >= 41 && i <= 201 && (i - 41) % 40 == 0)) bad_d++;
      if (s_act[i] !== (i >= 1 && i <= 200)) bad_a++;
      if (i > 200 && s_ser[i] !== 1'b1) bad_i++;
    end
    tests++;
    if (bad_d != 0) begin
      fails++;
      $display("FAIL b2b_done: %0d cycles with wrong done, want 0", bad_d);
    end
    tests++;
    if (bad_a != 0) begin
      fails++;
      $display("FAIL b2b_active: %0d cycles with wrong active, want 0", bad_a);
    end
    tests++;
    if (bad_i != 0 || s_cnt[209] !== 3'd0) begin
      fails++;
      $display("FAIL b2b_drop: %0d non-idle tail cycles, count=%0d, want 0 and 0", bad_i, s_cnt[209]);
    end
  endtask
  task automatic test_reset_mid_frame;
    logic [63:0] line, dn, act, exp;
    int          bad;
    @(negedge clk);
    pm = 2'b00;
    two = 1'b0;
    dv = 1;
    byte_in = 8'hC3;
    @(negedge clk);
    byte_in = 8'h11;
    @(negedge clk);
    byte_in = 8'h22;
    @(negedge clk);
    dv = 0;
    tests++;
    if (count !== 3'd2) begin
      fails++;
      $display("FAIL rst_queued: count=%0d, want 2", count);
    end
    repeat (16) @(negedge clk);
    tests++;
    if ({serial, active} !== 2'b01) begin
      fails++;
      $display("FAIL rst_bit3: s/a=%b in data bit 3, want 01", {serial, active});
    end
    rst = 1;
    #1;
    tests++;
    if ({serial, active, done, ready, count} !== 7'b1_0_0_1_000) begin
      fails++;
      $display("FAIL rst_mid_async: got s/a/d/r/cnt=%b, want 1001000", {serial, active, done, ready, count});
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    rst = 0;
    repeat (12) begin
      @(negedge clk);
      if ({serial, active, done, count} !== 6'b1_0_0_000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_flush: %0d cycles not idle/empty after reset, want 0", bad);
    end
    write_word(0, 8'h3C, 2'b00, 1'b0);
    capture(0, 41, -1, 2'b00, line, dn, act);
    exp = expand({6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    exp[40] = 1'b1;
    tests++;
    if (line !== exp) begin
      fails++;
      $display("FAIL rst_3c_line: got %h, want %h", line, exp);
    end
    tests++;
    if (dn !== 64'b1 << 40) begin
      fails++;
      $display("FAIL rst_3c_done: got %h, want %h", dn, 64'b1 << 40);
    end
  endtask
  task automatic test_five_bit;
    logic [63:0] line, dn, act, exp;
    write_word(1, 8'h1F, 2'b10, 1'b0);
    capture(1, 33, -1, 2'b00, line, dn, act);
    exp = expand({8'b0, 1'b1, 1'b0, 5'h1F, 1'b0}, 8);
    exp[32] = 1'b1;
    tests++;
    if (line !== exp) begin
      fails++;
      $display("FAIL db5_line: got %h, want %h", line, exp);
    end
    tests++;
    if (dn !== 64'b1 << 32) begin
      fails++;
      $display("FAIL db5_done: got %h, want %h", dn, 64'b1 << 32);
    end
    tests++;
    if (act !== (64'b1 << 32) - 1) begin
      fails++;
      $display("FAIL db5_active: got %h, want %h", act, (64'b1 << 32) - 1);
    end
  endtask
  initial begin
    test_reset;
    test_frame_a5;
    test_parity;
    test_two_stop;
    test_back_to_back;
    test_reset_mid_frame;
    test_five_bit;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
